// File: rtl/slot_output_table.sv
// Per-slot sign-magnitude linear output store: mixer read port, a feedback port returning
// the floor-average of current and previous samples, and a sweep FSM that zeroes the table.
module slot_output_table #(
  parameter int NUM_SLOTS = 18,
  parameter int VW        = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clkena,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic          wr_sign,
  input  logic [VW-1:0] wr_value,
  input  logic [4:0]    maddr,
  output logic          mdata_sign,
  output logic [VW-1:0] mdata_value,
  input  logic [4:0]    fb_addr,
  output logic          fb_sign,
  output logic [VW-1:0] fb_value,
  input  logic          clear,
  output logic          busy
);

  localparam int         EW    = 2 * (VW + 1);
  localparam logic [4:0] LIMIT = 5'(NUM_SLOTS);
  localparam logic [4:0] LAST  = 5'(NUM_SLOTS - 1);
  localparam logic [VW:0] ONE  = (VW + 1)'(1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t      state, next_state;
  logic [4:0]  cnt, next_cnt;

  // Entry layout: {cur_sign, cur_value, prev_sign, prev_value}
  logic [EW-1:0] mem [NUM_SLOTS];
  logic          mem_we;
  logic [4:0]    mem_waddr;
  logic [EW-1:0] mem_wdata;

  logic [VW:0]   m_cur;
  logic [EW-1:0] fb_entry;
  logic [VW:0]   cur_tc, prev_tc, fb_avg;
  logic [VW+1:0] fb_sum;
  logic [VW-1:0] fb_mag;

  assign busy = (state == SWEEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // The sweep owns the single write port; operator writes only land while idle.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (clear) begin
          next_state = SWEEP;
          next_cnt   = '0;
        end else if (clkena && wr_en && (wr_addr < LIMIT)) begin
          mem_we    = 1'b1;
          mem_wdata = {wr_sign & (|wr_value), wr_value, mem[wr_addr][EW-1 -: VW+1]};
        end
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        if (clear) begin
          next_cnt = '0;
        end else if (cnt == LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 5'd1;
        end
      end
      default: begin
        next_state = SWEEP;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset)
      mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    m_cur    = '0;
    fb_entry = '0;
    if (maddr < LIMIT)
      m_cur = mem[maddr][EW-1 -: VW+1];
    if (fb_addr < LIMIT)
      fb_entry = mem[fb_addr];
  end

  // Average in two's complement; dropping the sum's LSB floors toward minus infinity.
  always_comb begin
    cur_tc  = fb_entry[EW-1] ? (~{1'b0, fb_entry[EW-2 -: VW]}) + ONE
                             : {1'b0, fb_entry[EW-2 -: VW]};
    prev_tc = fb_entry[VW]   ? (~{1'b0, fb_entry[VW-1:0]}) + ONE
                             : {1'b0, fb_entry[VW-1:0]};
    fb_sum  = {cur_tc[VW], cur_tc} + {prev_tc[VW], prev_tc};
    fb_avg  = (VW + 1)'(fb_sum >> 1);
    fb_mag  = fb_avg[VW] ? VW'((~fb_avg) + ONE) : VW'(fb_avg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdata_sign  <= 1'b0;
      mdata_value <= '0;
      fb_sign     <= 1'b0;
      fb_value    <= '0;
    end else if (clkena) begin
      if (state == SWEEP) begin
        mdata_sign  <= 1'b0;
        mdata_value <= '0;
        fb_sign     <= 1'b0;
        fb_value    <= '0;
      end else begin
        mdata_sign  <= m_cur[VW];
        mdata_value <= m_cur[VW-1:0];
        fb_sign     <= fb_avg[VW];
        fb_value    <= fb_mag;
      end
    end
  end

endmodule

// File: tb/tb_slot_output_table.sv
// Directed self-checking bench for slot_output_table: sweep timing, writes, both read ports.
module tb_slot_output_table;

  logic       clk, reset, clkena, wr_en, wr_sign, clear;
  logic [4:0] wr_addr, maddr, fb_addr;
  logic [8:0] wr_value;
  logic       mdata_sign, fb_sign, busy;
  logic [8:0] mdata_value, fb_value;

  int vectors = 0;
  int miscompares = 0;

  slot_output_table #(.NUM_SLOTS(18), .VW(9)) dut (
    .clk(clk), .reset(reset), .clkena(clkena),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sign(wr_sign), .wr_value(wr_value),
    .maddr(maddr), .mdata_sign(mdata_sign), .mdata_value(mdata_value),
    .fb_addr(fb_addr), .fb_sign(fb_sign), .fb_value(fb_value),
    .clear(clear), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [4:0] a, input logic s, input logic [8:0] v);
    wr_en = 1'b1; wr_addr = a; wr_sign = s; wr_value = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_slot(input logic [4:0] a);
    maddr = a; fb_addr = a;
    tick();
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b1 || {mdata_sign, mdata_value} !== 10'd0 || {fb_sign, fb_value} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got busy=%b m=%b/%0d fb=%b/%0d required busy=1 m=0/0 fb=0/0",
               busy, mdata_sign, mdata_value, fb_sign, fb_value);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("[TB] FAIL reset_sweep_len: got %0d clks required 18", n);
    end
    for (int a = 0; a < 18; a++) begin
      read_slot(5'(a));
      vectors++;
      if ({mdata_sign, mdata_value} !== 10'd0 || {fb_sign, fb_value} !== 10'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_read[%0d]: got m=%b/%0d fb=%b/%0d required 0/0 0/0",
                 a, mdata_sign, mdata_value, fb_sign, fb_value);
      end
    end
  endtask

  task automatic test_write_read();
    write_slot(5'd5, 1'b0, 9'd100);
    write_slot(5'd5, 1'b1, 9'd40);
    read_slot(5'd5);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b1, 9'd40}) begin
      miscompares++;
      $display("[TB] FAIL wr_mdata: got %b/%0d required 1/40", mdata_sign, mdata_value);
    end
    vectors++;
    if ({fb_sign, fb_value} !== {1'b0, 9'd30}) begin
      miscompares++;
      $display("[TB] FAIL wr_fb: got %b/%0d required 0/30", fb_sign, fb_value);
    end
  endtask

  task automatic test_feedback_rounding();
    write_slot(5'd3, 1'b1, 9'd1);
    write_slot(5'd3, 1'b1, 9'd2);
    write_slot(5'd4, 1'b0, 9'd1);
    write_slot(5'd4, 1'b1, 9'd1);
    write_slot(5'd6, 1'b0, 9'd3);
    write_slot(5'd6, 1'b0, 9'd0);
    read_slot(5'd3);
    vectors++;
    if ({fb_sign, fb_value} !== {1'b1, 9'd2}) begin
      miscompares++;
      $display("[TB] FAIL fb_neg_floor: got %b/%0d required 1/2", fb_sign, fb_value);
    end
    read_slot(5'd4);
    vectors++;
    if ({fb_sign, fb_value} !== {1'b0, 9'd0}) begin
      miscompares++;
      $display("[TB] FAIL fb_zero: got %b/%0d required 0/0", fb_sign, fb_value);
    end
    read_slot(5'd6);
    vectors++;
    if ({fb_sign, fb_value} !== {1'b0, 9'd1}) begin
      miscompares++;
      $display("[TB] FAIL fb_pos_floor: got %b/%0d required 0/1", fb_sign, fb_value);
    end
  endtask

  task automatic test_read_before_write();
    write_slot(5'd7, 1'b0, 9'd20);
    maddr = 5'd7; fb_addr = 5'd7;
    write_slot(5'd7, 1'b0, 9'd511);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd20} || {fb_sign, fb_value} !== {1'b0, 9'd10}) begin
      miscompares++;
      $display("[TB] FAIL rbw_old: got m=%b/%0d fb=%b/%0d required 0/20 0/10",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    tick();
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd511} || {fb_sign, fb_value} !== {1'b0, 9'd265}) begin
      miscompares++;
      $display("[TB] FAIL rbw_new: got m=%b/%0d fb=%b/%0d required 0/511 0/265",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    write_slot(5'd7, 1'b0, 9'd511);
    tick();
    vectors++;
    if ({fb_sign, fb_value} !== {1'b0, 9'd511}) begin
      miscompares++;
      $display("[TB] FAIL fb_max: got %b/%0d required 0/511", fb_sign, fb_value);
    end
  endtask

  task automatic test_clkena();
    write_slot(5'd8, 1'b0, 9'd50);
    read_slot(5'd8);
    clkena = 1'b0;
    maddr = 5'd9; fb_addr = 5'd9;
    write_slot(5'd8, 1'b0, 9'd77);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd50} || {fb_sign, fb_value} !== {1'b0, 9'd25}) begin
      miscompares++;
      $display("[TB] FAIL clkena_hold: got m=%b/%0d fb=%b/%0d required 0/50 0/25",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    clkena = 1'b1;
    read_slot(5'd8);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd50} || {fb_sign, fb_value} !== {1'b0, 9'd25}) begin
      miscompares++;
      $display("[TB] FAIL clkena_nowrite: got m=%b/%0d fb=%b/%0d required 0/50 0/25",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    read_slot(5'd20);
    vectors++;
    if ({mdata_sign, mdata_value} !== 10'd0 || {fb_sign, fb_value} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL bad_addr: got m=%b/%0d fb=%b/%0d required 0/0 0/0",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    write_slot(5'd9, 1'b1, 9'd0);
    read_slot(5'd9);
    vectors++;
    if ({mdata_sign, mdata_value} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL neg_zero: got %b/%0d required 0/0", mdata_sign, mdata_value);
    end
  endtask

  task automatic test_back_to_back();
    write_slot(5'd0, 1'b0, 9'd1);
    write_slot(5'd1, 1'b1, 9'd2);
    write_slot(5'd17, 1'b0, 9'd3);
    write_slot(5'd18, 1'b1, 9'd99);
    read_slot(5'd0);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_slot0: got %b/%0d required 0/1", mdata_sign, mdata_value);
    end
    read_slot(5'd1);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b1, 9'd2} || {fb_sign, fb_value} !== {1'b1, 9'd1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_slot1: got m=%b/%0d fb=%b/%0d required 1/2 1/1",
               mdata_sign, mdata_value, fb_sign, fb_value);
    end
    read_slot(5'd17);
    vectors++;
    if ({mdata_sign, mdata_value} !== {1'b0, 9'd3}) begin
      miscompares++;
      $display("[TB] FAIL b2b_slot17: got %b/%0d required 0/3", mdata_sign, mdata_value);
    end
  endtask

  task automatic test_clear_restart();
    int n;
    write_slot(5'd10, 1'b0, 9'd33);
    maddr = 5'd10; fb_addr = 5'd10;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_busy: got %b required 1", busy);
    end
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) write_slot(5'd11, 1'b0, 9'd44);
      else tick();
    end
    vectors++;
    if ({mdata_sign, mdata_value} !== 10'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sweep_read: got m=%b/%0d busy=%b required 0/0 busy=1",
               mdata_sign, mdata_value, busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 12) write_slot(5'd12, 1'b1, 9'd55);
      else tick();
      n++;
    end
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("[TB] FAIL restart_len: got %0d clks required 18", n);
    end
    for (int a = 0; a < 18; a++) begin
      read_slot(5'(a));
      vectors++;
      if ({mdata_sign, mdata_value} !== 10'd0 || {fb_sign, fb_value} !== 10'd0) begin
        miscompares++;
        $display("[TB] FAIL clear_read[%0d]: got m=%b/%0d fb=%b/%0d required 0/0 0/0",
                 a, mdata_sign, mdata_value, fb_sign, fb_value);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clkena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sign = 1'b0;
    wr_value = '0; maddr = '0; fb_addr = '0; clear = 1'b0;
    test_reset();
    test_write_read();
    test_feedback_rounding();
    test_read_before_write();
    test_clkena();
    test_back_to_back();
    test_clear_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_output_table.md
Name: slot_output_table

Overview:
- Per-slot linear output store. It is the producer/responder side of the mixer's `maddr`/`mdata` read interface.
- The operator pipeline writes each slot's sign-magnitude linear output. The mixer reads the current sample by slot address.
- A second read port returns the average of each slot's current and previous samples, for modulator self-feedback.
- A sweep FSM zeroes the store after reset or on request.

Parameters:
- NUM_SLOTS, 18, number of valid slot entries (addresses 0..NUM_SLOTS-1).
- VW, 9, magnitude width of a linear sample (sign bit carried separately).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clkena  in  1  pipeline enable; gates writes and read-register updates
- wr_en  in  1  write strobe from operator stage
- wr_addr  in  5  slot written
- wr_sign  in  1  sign of written sample (1 = negative)
- wr_value  in  VW  magnitude of written sample
- maddr  in  5  mixer read address
- mdata_sign  out  1  mixer read sign
- mdata_value  out  VW  mixer read magnitude
- fb_addr  in  5  feedback read address
- fb_sign  out  1  feedback average sign
- fb_value  out  VW  feedback average magnitude
- clear  in  1  request full table flush
- busy  out  1  sweep in progress

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Storage: per entry {cur_sign, cur_value, prev_sign, prev_value}. Single-clock RAM-inferable; at most one entry is written per clk.

Reset:
- mdata_sign/value = 0, fb_sign/value = 0, busy = 1.
- FSM enters SWEEP with cnt = 0.
- Table contents are undefined until the sweep completes.

FSM:
- IDLE: busy = 0. `clear` = 1 → SWEEP, cnt = 0.
- SWEEP: busy = 1. Every clk, independent of `clkena`: entry[cnt] is fully zeroed and cnt increments.
- After writing cnt == NUM_SLOTS-1 → IDLE; busy drops on the following cycle.
- `clear` asserted during SWEEP restarts cnt at 0.
- `reset` mid-sweep restarts the sweep.

Write (IDLE only, clkena = 1, wr_en = 1, wr_addr < NUM_SLOTS):
- prev ← cur and cur ← {wr_sign, wr_value}, in a single clk.
- Negative zero (sign = 1, value = 0) is stored as +0.
- Writes with wr_addr ≥ NUM_SLOTS are ignored.
- Writes during SWEEP are dropped.

Mixer read (clkena = 1):
- {mdata_sign, mdata_value} ← cur[maddr]; latency 1 enabled cycle.
- clkena = 0: outputs hold.
- Read-before-write: a same-cycle write to the same entry returns the old cur.
- maddr ≥ NUM_SLOTS, or state SWEEP: registers load 0.

Feedback read (clkena = 1, latency 1):
- Convert cur and prev to (VW+1)-bit two's complement.
- Sum at VW+2 bits, then arithmetic shift right 1 (floor toward −∞).
- Convert the result back to sign-magnitude; a zero result is +0. The magnitude always fits in VW bits.
- Same read-before-write, invalid-address and SWEEP rules as the mixer port.

Test Plan:
- Reset held 1 cycle, then released → busy = 1 for exactly 18 clks, then 0. Read of every address 0..17 → mdata = +0, fb = +0.
- Write slot 5 = +100, then slot 5 = −40 (clkena = 1) → maddr = 5 gives sign 1 / value 40 next enabled cycle. fb_addr = 5 gives floor((100−40)/2) = +30.
- Slot 3 written −1 then −2 → fb = floor(−3/2) = −2 (sign 1, value 2). Slot 4 written +1 then −1 → fb = +0, sign 0.
- Write slot 7 = +511 and read maddr = 7 in the same cycle → old value returned. Next read returns +511. Two writes of +511 → fb = +511 (no overflow).
- clkena = 0 with wr_en = 1 → no table change and outputs hold. maddr = 20 → mdata = +0. Write of −0 → reads as sign 0.
- Assert clear, then re-assert clear at sweep cycle 10 → busy stays high until 18 clks after the second assertion. Writes during the sweep are lost. All entries read +0 afterward.
